serial_sub: RTL and testbench

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/serial_sub_fs.sv | 16 +
 rtl/serial_sub.sv | 105 ++++++++++
 tb/tb_serial_sub.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_fs.sv
// One-bit full subtractor (a - b - bin), the per-bit datapath of serial_sub.
module fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  logic axb;

  assign axb = a ^ b;
  assign d   = axb ^ bin;
  assign bo  = (~a & b) | (~axb & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b, one bit per cycle LSB-first, final borrow on bout.
// Optional signed-overflow flag on port ovf when SERIAL_SUB_OVF_EN is defined.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CNT_W-1:0] cnt;
  logic             bin;
  logic             d, bo;
  logic             last;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb, b_msb;
`endif

  fs u_fs (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .bin(bin),
    .d  (d),
    .bo (bo)
  );

  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      cnt   <= '0;
      bin   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            cnt  <= '0;
            bin  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            ovf   <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          res  <= {d, res[WIDTH-1:1]};
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          bin  <= bo;
          cnt  <= cnt + CNT_W'(1);
`ifdef SERIAL_SUB_OVF_EN
          // d is the result MSB on the final shift, so the flag lands together with diff
          if (last) ovf <= (a_msb != b_msb) && (d != a_msb);
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign diff = res;
  assign bout = bin;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8): vector table plus restart, reset-abort and back-to-back sequences.
module tb_serial_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, bout;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Start is raised just after an edge; it is accepted at the next edge and
  // done should be seen 9 edges after it was raised.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, output int lat);
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    lat = 1;
    check("busy_after_accept", busy, 1'b1);
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int ndone;
    int k, prev, cnt;
    logic [W-1:0] diff_seen;
    logic [W-1:0] xa[4];
    logic [W-1:0] xb[4];

    vecs[0] = '{8'd200, 8'd55,  8'd145,  1'b0, 1'b0};
    vecs[1] = '{8'd5,   8'd10,  8'd251,  1'b1, 1'b0};
    vecs[2] = '{8'd0,   8'd1,   8'd255,  1'b1, 1'b0};
    vecs[3] = '{8'd0,   8'd0,   8'd0,    1'b0, 1'b0};
    vecs[4] = '{8'h80,  8'h01,  8'h7F,   1'b0, 1'b1};
    vecs[5] = '{8'h10,  8'h01,  8'h0F,   1'b0, 1'b0};
    vecs[6] = '{8'h7F,  8'hFF,  8'h80,   1'b1, 1'b1};
    vecs[7] = '{8'hFF,  8'hFF,  8'h00,   1'b0, 1'b0};
    vecs[8] = '{8'hFF,  8'h00,  8'hFF,   1'b0, 1'b0};

    // reset state
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 8'd0);
    check("rst_bout", bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", ovf, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].va, vecs[i].vb, lat);
      check($sformatf("vec%0d_latency", i), lat, 9);
      check($sformatf("vec%0d_diff", i), diff, vecs[i].exp_diff);
      check($sformatf("vec%0d_bout", i), bout, vecs[i].exp_bout);
`ifdef SERIAL_SUB_OVF_EN
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
`endif
      @(negedge clk);
      check($sformatf("vec%0d_done_single", i), done, 1'b0);
      check($sformatf("vec%0d_hold_diff", i), diff, vecs[i].exp_diff);
      check($sformatf("vec%0d_hold_bout", i), bout, vecs[i].exp_bout);
    end

    // start re-pulsed with 1-1 during the third SHIFT cycle must be ignored
    @(negedge clk);
    a = 8'd200; b = 8'd55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'd1; b = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    diff_seen = '0;
    for (int c = 0; c < 15; c++) begin
      if (done) begin
        ndone++;
        diff_seen = diff;
      end
      @(negedge clk);
    end
    check("restart_done_count", ndone, 1);
    check("restart_diff", diff_seen, 8'd145);

    // reset during the fourth SHIFT cycle aborts with no done pulse
    @(negedge clk);
    a = 8'd200; b = 8'd55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_diff", diff, 8'd0);
    check("abort_bout", bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    check("abort_ovf", ovf, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_op(8'd9, 8'd4, lat);
    check("post_abort_latency", lat, 9);
    check("post_abort_diff", diff, 8'd5);
    check("post_abort_bout", bout, 1'b0);

    // start held high: one operation every W+2 cycles, each against a - b
    xa[0] = 8'd37;  xb[0] = 8'd100;
    xa[1] = 8'd250; xb[1] = 8'd3;
    xa[2] = 8'd128; xb[2] = 8'd128;
    xa[3] = 8'd1;   xb[3] = 8'd2;
    @(negedge clk);
    start = 1'b1;
    a = xa[0]; b = xb[0];
    k = 0; prev = 0; cnt = 0;
    for (int c = 0; c < 80 && k < 4; c++) begin
      @(negedge clk);
      cnt++;
      if (done) begin
        check($sformatf("b2b%0d_diff", k), diff, W'(xa[k] - xb[k]));
        check($sformatf("b2b%0d_bout", k), bout, (xa[k] < xb[k]));
        if (k == 0) check("b2b_first_latency", cnt, 9);
        else        check($sformatf("b2b%0d_period", k), cnt - prev, W + 2);
        prev = cnt;
        k++;
        if (k < 4) begin
          a = xa[k]; b = xb[k];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_op_count", k, 4);
    repeat (2) @(negedge clk);
    check("b2b_idle_after", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
